// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the slot-based bus arbiter.
//   state_t   - arbiter state machine encoding
//   grantee_t - owner of the current bus slot
//   SLOT_COUNT / SLOT_W - slot ring size and slot index width
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACTIVE,
      RETIRE
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      CPU,
      VIDEO,
      MCU
   } grantee_t;

   localparam int unsigned SLOT_COUNT = 8;
   localparam int unsigned SLOT_W     = $clog2(SLOT_COUNT);

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick (combinational).
//   req[1:0]   - request vector (bit 0 = video, bit 1 = MCU in bus_arbiter)
//   last       - index of the requester that won the last completed transaction
//   advance    - arbitration strobe; no grant is produced while low
//   grant[1:0] - one-hot winner, or zero when nothing is requested
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       advance,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      if (advance) begin
         unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: whoever did not win last time goes first.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
         endcase
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: 8-slot RAM bus arbiter shared by CPU, video fetch and MCU/SPI.
//   clk_sys_i      - 64 MHz system clock
//   reset_i        - asynchronous active-high reset
//   setup_i        - slot start strobe (every 8 clocks)
//   enable_i       - bus enable strobe (setup + 2)
//   disable_i      - bus disable strobe (setup + 6)
//   cpu_rw_i       - CPU direction, 1 = read
//   video_req_i    - video fetch request, held until video_done_o
//   mcu_req_i      - MCU request, held until mcu_done_o
//   mcu_we_i       - MCU direction, 1 = write
//   grant_*_o      - one-hot (or zero) slot owner
//   ram_oe_o       - RAM output enable
//   ram_we_o       - RAM write enable
//   video_done_o   - one-cycle completion pulse for video
//   mcu_done_o     - one-cycle completion pulse for MCU
//   slot_o         - current slot index
//   err_o          - one-cycle pulse when a transaction is aborted by setup_i
module bus_arbiter
   import bus_pkg::*;
#(
   parameter logic [SLOT_W-1:0] CPU_SLOT = 3'd7
) (
   input  logic              clk_sys_i,
   input  logic              reset_i,
   input  logic              setup_i,
   input  logic              enable_i,
   input  logic              disable_i,
   input  logic              cpu_rw_i,
   input  logic              video_req_i,
   input  logic              mcu_req_i,
   input  logic              mcu_we_i,
   output logic              grant_cpu_o,
   output logic              grant_video_o,
   output logic              grant_mcu_o,
   output logic              ram_oe_o,
   output logic              ram_we_o,
   output logic              video_done_o,
   output logic              mcu_done_o,
   output logic [SLOT_W-1:0] slot_o,
   output logic              err_o
);

   state_t              state_q;
   logic [SLOT_W-1:0]   slot_q;
   logic                first_q;  // no slot started since reset: next setup selects slot 0
   logic                last_q;   // 1 = MCU won the last completed transaction
   logic                rd_q;     // direction of the current transaction, 1 = read

   logic [SLOT_W-1:0]   next_slot;
   logic [1:0]          pick;
   logic                advance;
   grantee_t            new_owner;
   logic                new_rd;

   assign next_slot = first_q ? '0 : slot_q + SLOT_W'(1);
   assign advance   = setup_i && (next_slot != CPU_SLOT);
   assign slot_o    = slot_q;

   rr_pick2 u_rr_pick2 (
      .req     ({mcu_req_i, video_req_i}),
      .last    (last_q),
      .advance (advance),
      .grant   (pick)
   );

   always_comb begin
      new_owner = NONE;
      if (next_slot == CPU_SLOT) begin
         new_owner = CPU;
      end else if (pick[0]) begin
         new_owner = VIDEO;
      end else if (pick[1]) begin
         new_owner = MCU;
      end

      unique case (new_owner)
         CPU:     new_rd = cpu_rw_i;
         MCU:     new_rd = ~mcu_we_i;
         default: new_rd = 1'b1;
      endcase
   end

   always_ff @(posedge clk_sys_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= IDLE;
         slot_q        <= '0;
         first_q       <= 1'b1;
         last_q        <= 1'b1;
         rd_q          <= 1'b0;
         grant_cpu_o   <= 1'b0;
         grant_video_o <= 1'b0;
         grant_mcu_o   <= 1'b0;
         ram_oe_o      <= 1'b0;
         ram_we_o      <= 1'b0;
         video_done_o  <= 1'b0;
         mcu_done_o    <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         video_done_o <= 1'b0;
         mcu_done_o   <= 1'b0;
         err_o        <= 1'b0;

         if (setup_i) begin
            // A new slot always wins: any transaction still in flight is
            // aborted and the new slot is arbitrated in the same cycle.
            if (state_q == SETUP || state_q == ACTIVE) begin
               err_o <= 1'b1;
            end
            ram_oe_o      <= 1'b0;
            ram_we_o      <= 1'b0;
            slot_q        <= next_slot;
            first_q       <= 1'b0;
            rd_q          <= new_rd;
            grant_cpu_o   <= (new_owner == CPU);
            grant_video_o <= (new_owner == VIDEO);
            grant_mcu_o   <= (new_owner == MCU);
            state_q       <= (new_owner == NONE) ? IDLE : SETUP;
         end else begin
            unique case (state_q)
               SETUP: begin
                  if (enable_i) begin
                     state_q  <= ACTIVE;
                     ram_oe_o <= rd_q;
                     ram_we_o <= ~rd_q;
                  end
               end
               ACTIVE: begin
                  if (disable_i) begin
                     state_q      <= RETIRE;
                     ram_oe_o     <= 1'b0;
                     ram_we_o     <= 1'b0;
                     video_done_o <= grant_video_o;
                     mcu_done_o   <= grant_mcu_o;
                     if (grant_video_o) begin
                        last_q <= 1'b0;
                     end else if (grant_mcu_o) begin
                        last_q <= 1'b1;
                     end
                  end
               end
               RETIRE: begin
                  state_q       <= IDLE;
                  grant_cpu_o   <= 1'b0;
                  grant_video_o <= 1'b0;
                  grant_mcu_o   <= 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed slot-level bench for bus_arbiter.
// Each slot is eight clocks: setup on cycle 0, enable on 2, disable on 6.
module tb_bus_arbiter;

   logic       clk_sys_i = 1'b0;
   logic       reset_i   = 1'b1;
   logic       setup_i   = 1'b0;
   logic       enable_i  = 1'b0;
   logic       disable_i = 1'b0;
   logic       cpu_rw_i  = 1'b1;
   logic       video_req_i = 1'b0;
   logic       mcu_req_i = 1'b0;
   logic       mcu_we_i  = 1'b0;
   logic       grant_cpu_o, grant_video_o, grant_mcu_o;
   logic       ram_oe_o, ram_we_o, video_done_o, mcu_done_o, err_o;
   logic [2:0] slot_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Per-slot record; bit c of a mask is the output sampled 1 ns after edge c.
   logic [2:0] r_slot;
   logic [2:0] r_grant;   // {cpu, video, mcu} right after the setup edge
   logic [7:0] r_oe, r_we, r_vd, r_md, r_err;
   int unsigned r_bad;    // cycles with more than one grant high

   bus_arbiter #(.CPU_SLOT(3'd7)) dut (
      .clk_sys_i     (clk_sys_i),
      .reset_i       (reset_i),
      .setup_i       (setup_i),
      .enable_i      (enable_i),
      .disable_i     (disable_i),
      .cpu_rw_i      (cpu_rw_i),
      .video_req_i   (video_req_i),
      .mcu_req_i     (mcu_req_i),
      .mcu_we_i      (mcu_we_i),
      .grant_cpu_o   (grant_cpu_o),
      .grant_video_o (grant_video_o),
      .grant_mcu_o   (grant_mcu_o),
      .ram_oe_o      (ram_oe_o),
      .ram_we_o      (ram_we_o),
      .video_done_o  (video_done_o),
      .mcu_done_o    (mcu_done_o),
      .slot_o        (slot_o),
      .err_o         (err_o)
   );

   always #8 clk_sys_i = ~clk_sys_i;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned outs();
      return int'({grant_cpu_o, grant_video_o, grant_mcu_o, ram_oe_o, ram_we_o,
                   video_done_o, mcu_done_o, err_o, slot_o});
   endfunction

   // One slot of strobes. supp suppresses disable_i, rst_at pulses reset
   // after the sample of that cycle, drop_at drops mcu_req_i on that cycle.
   task automatic run_slot(input bit supp, input int rst_at, input int drop_at);
      r_oe = '0; r_we = '0; r_vd = '0; r_md = '0; r_err = '0; r_bad = 0;
      r_slot = '0; r_grant = '0;
      for (int c = 0; c < 8; c++) begin
         if (c == drop_at) mcu_req_i = 1'b0;
         setup_i   = (c == 0);
         enable_i  = (c == 2);
         disable_i = (c == 6) && !supp;
         @(posedge clk_sys_i);
         #1;
         if (c == 0) begin
            r_slot  = slot_o;
            r_grant = {grant_cpu_o, grant_video_o, grant_mcu_o};
         end
         r_oe[c]  = ram_oe_o;
         r_we[c]  = ram_we_o;
         r_vd[c]  = video_done_o;
         r_md[c]  = mcu_done_o;
         r_err[c] = err_o;
         if (int'(grant_cpu_o) + int'(grant_video_o) + int'(grant_mcu_o) > 1) r_bad++;
         if (c == rst_at) begin
            #2 reset_i = 1'b1;
            #1 check("rst_async_outs", outs(), 0);
            #1 reset_i = 1'b0;
         end
      end
      setup_i = 1'b0; enable_i = 1'b0; disable_i = 1'b0;
   endtask

   task automatic expect_slot(input string tag, input int unsigned slot, input int unsigned grant,
                              input int unsigned oe, input int unsigned we, input int unsigned vd,
                              input int unsigned md, input int unsigned er);
      check({tag, "_slot"},  r_slot,  slot);
      check({tag, "_grant"}, r_grant, grant);
      check({tag, "_oe"},    r_oe,    oe);
      check({tag, "_we"},    r_we,    we);
      check({tag, "_vdone"}, r_vd,    vd);
      check({tag, "_mdone"}, r_md,    md);
      check({tag, "_err"},   r_err,   er);
      check({tag, "_onehot"}, r_bad,  0);
   endtask

   initial begin
      int unsigned vd_total;
      int unsigned md_total;
      int unsigned g;

      // Reset held: everything quiet.
      repeat (3) @(posedge clk_sys_i);
      #1 check("reset_outs", outs(), 0);
      reset_i = 1'b0;

      // Eight quiet slots: only the CPU slot is granted, as a read.
      for (int s = 0; s < 8; s++) begin
         run_slot(1'b0, -1, -1);
         expect_slot("quiet", s, (s == 7) ? 3'b100 : 3'b000, (s == 7) ? 8'h3C : 8'h00, 0, 0, 0, 0);
      end

      // Both requesters for 16 slots: strict alternation, CPU keeps slot 7.
      video_req_i = 1'b1; mcu_req_i = 1'b1; mcu_we_i = 1'b0;
      vd_total = 0; md_total = 0;
      for (int i = 0; i < 16; i++) begin
         if (i % 8 == 7)                         g = 3'b100;
         else if (((i % 8) % 2 == 0) ^ (i >= 8)) g = 3'b010;
         else                                    g = 3'b001;
         run_slot(1'b0, -1, -1);
         expect_slot("rr", i % 8, g, 8'h3C, 0, (g == 3'b010) ? 8'h40 : 8'h00,
                     (g == 3'b001) ? 8'h40 : 8'h00, 0);
         vd_total += $countones(r_vd);
         md_total += $countones(r_md);
      end
      check("rr_vdone_total", vd_total, 7);
      check("rr_mdone_total", md_total, 7);
      video_req_i = 1'b0; mcu_req_i = 1'b0;

      // MCU write in slot 2.
      run_slot(1'b0, -1, -1);
      expect_slot("pre_wr0", 0, 0, 0, 0, 0, 0, 0);
      run_slot(1'b0, -1, -1);
      expect_slot("pre_wr1", 1, 0, 0, 0, 0, 0, 0);
      mcu_req_i = 1'b1; mcu_we_i = 1'b1;
      run_slot(1'b0, -1, -1);
      expect_slot("mcu_wr", 2, 3'b001, 8'h00, 8'h3C, 0, 8'h40, 0);
      mcu_req_i = 1'b0; mcu_we_i = 1'b0;

      // Video slot 4 never sees disable: aborted by slot 5's setup.
      run_slot(1'b0, -1, -1);
      expect_slot("pre_ab3", 3, 0, 0, 0, 0, 0, 0);
      video_req_i = 1'b1;
      run_slot(1'b1, -1, -1);
      expect_slot("abort4", 4, 3'b010, 8'hFC, 0, 0, 0, 0);
      run_slot(1'b0, -1, -1);
      expect_slot("after5", 5, 3'b010, 8'h3C, 0, 8'h40, 0, 8'h01);
      video_req_i = 1'b0;

      // CPU write in slot 7.
      run_slot(1'b0, -1, -1);
      expect_slot("pre_cw6", 6, 0, 0, 0, 0, 0, 0);
      cpu_rw_i = 1'b0;
      run_slot(1'b0, -1, -1);
      expect_slot("cpu_wr", 7, 3'b100, 8'h00, 8'h3C, 0, 0, 0);
      cpu_rw_i = 1'b1;

      // Reset pulsed during ACTIVE of an MCU read in slot 1.
      run_slot(1'b0, -1, -1);
      expect_slot("pre_rs0", 0, 0, 0, 0, 0, 0, 0);
      mcu_req_i = 1'b1;
      run_slot(1'b0, 3, -1);
      expect_slot("rst_mid", 1, 3'b001, 8'h0C, 0, 0, 0, 0);

      // Restart at slot 0; MCU request dropped mid-ACTIVE still completes.
      run_slot(1'b0, -1, 3);
      expect_slot("drop", 0, 3'b001, 8'h3C, 0, 0, 8'h40, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog: the stimulus is fixed-length, so this only fires on a stall.
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

endmodule
